// File: rtl/ctrl_param_pkg.sv
// Shared constants, field layout and reset defaults for the time-slot parameter bank.
package ctrl_param_pkg;

  // Command word layout
  localparam int CMD_GLOBAL_BIT = 31;
  localparam int CMD_NCMD_LSB   = 27;
  localparam int CMD_CH_LSB     = 23;
  localparam int CMD_SLOT_LSB   = 19;
  localparam int CMD_DATA_LSB   = 0;
  localparam int CMD_IDX_W      = 4;
  localparam int CMD_DATA_W     = 16;

  // Local (per channel/slot) field codes, also used as READ field selectors
  localparam logic [3:0] NCMD_MASK  = 4'd1;
  localparam logic [3:0] NCMD_VCHN  = 4'd2;
  localparam logic [3:0] NCMD_HIT   = 4'd3;
  localparam logic [3:0] NCMD_GND   = 4'd4;
  localparam logic [3:0] NCMD_HUSH  = 4'd5;
  localparam logic [3:0] NCMD_COUNT = 4'd6;
  localparam logic [3:0] NCMD_DAC   = 4'd7;
  localparam logic [3:0] NCMD_RATIO = 4'd8;
  localparam logic [3:0] NCMD_TICK  = 4'd9;
  localparam logic [3:0] NCMD_TIME  = 4'd10;

  // Global command codes
  localparam logic [3:0] GCMD_COMMIT = 4'd1;
  localparam logic [3:0] GCMD_READ   = 4'd2;
  localparam logic [3:0] GCMD_REVERT = 4'd3;

  // Field widths
  localparam int MASK_W  = 4;
  localparam int VCHN_W  = 2;
  localparam int HIT_W   = 8;
  localparam int GND_W   = 8;
  localparam int HUSH_W  = 16;
  localparam int COUNT_W = 4;
  localparam int DAC_W   = 8;
  localparam int RATIO_W = 8;
  localparam int TICK_W  = 8;
  localparam int TIME_W  = 16;

  // Reset defaults
  localparam logic [TIME_W-1:0]  DEF_TS_TIME    = 16'd3600;
  localparam logic [HIT_W-1:0]   DEF_HIT        = 8'd40;
  localparam logic [HIT_W-1:0]   DEF_HIT_LAST   = 8'd20;
  localparam logic [GND_W-1:0]   DEF_GND        = 8'd40;
  localparam logic [GND_W-1:0]   DEF_GND_LAST   = 8'd60;
  localparam logic [COUNT_W-1:0] DEF_COUNT      = 4'd4;
  localparam logic [COUNT_W-1:0] DEF_COUNT_LAST = 4'd1;
  localparam logic [HUSH_W-1:0]  DEF_HUSH       = 16'd1000;
  localparam logic [TICK_W-1:0]  DEF_TICK       = 8'd64;
  localparam logic [RATIO_W-1:0] DEF_RATIO      = 8'd12;
  localparam logic [DAC_W-1:0]   DEF_DAC        = 8'd120;

  // Readback value for a bad index or field; {ch,slot} is OR-ed into the low byte
  localparam logic [31:0] ERR_READ_TAG = 32'hDEAD_0000;

  typedef struct packed {
    logic [MASK_W-1:0]  mask;
    logic [VCHN_W-1:0]  vchn;
    logic [HIT_W-1:0]   hit;
    logic [GND_W-1:0]   gnd;
    logic [HUSH_W-1:0]  hush;
    logic [COUNT_W-1:0] count;
    logic [DAC_W-1:0]   dac;
    logic [RATIO_W-1:0] ratio;
    logic [TICK_W-1:0]  tick;
  } chan_param_t;

  localparam int PARAM_W = $bits(chan_param_t);

  // Power-up contents of one (channel, slot) entry; the very last entry differs.
  function automatic chan_param_t default_entry(int c, int s, int n_ch, int n_slot);
    chan_param_t p;
    logic        last;
    last    = (c == n_ch - 1) && (s == n_slot - 1);
    p.mask  = MASK_W'(1 << (c % 4));
    p.vchn  = VCHN_W'(c);
    p.hit   = last ? DEF_HIT_LAST : DEF_HIT;
    p.gnd   = last ? DEF_GND_LAST : DEF_GND;
    p.hush  = DEF_HUSH;
    p.count = last ? DEF_COUNT_LAST : DEF_COUNT;
    p.dac   = DEF_DAC;
    p.ratio = DEF_RATIO;
    p.tick  = DEF_TICK;
    return p;
  endfunction

  // Places data into the field selected by ncmd, zero elsewhere. With all-ones
  // data the result doubles as the write mask for that field.
  function automatic chan_param_t place_field(logic [3:0] ncmd, logic [15:0] data);
    chan_param_t p;
    p = '0;
    case (ncmd)
      NCMD_MASK:  p.mask  = data[MASK_W-1:0];
      NCMD_VCHN:  p.vchn  = data[VCHN_W-1:0];
      NCMD_HIT:   p.hit   = data[HIT_W-1:0];
      NCMD_GND:   p.gnd   = data[GND_W-1:0];
      NCMD_HUSH:  p.hush  = data[HUSH_W-1:0];
      NCMD_COUNT: p.count = data[COUNT_W-1:0];
      NCMD_DAC:   p.dac   = data[DAC_W-1:0];
      NCMD_RATIO: p.ratio = data[RATIO_W-1:0];
      NCMD_TICK:  p.tick  = data[TICK_W-1:0];
      default:    p = '0;
    endcase
    return p;
  endfunction

  // Zero-extended extraction of one field for readback.
  function automatic logic [15:0] get_field(chan_param_t p, logic [3:0] ncmd);
    logic [15:0] v;
    case (ncmd)
      NCMD_MASK:  v = {12'd0, p.mask};
      NCMD_VCHN:  v = {14'd0, p.vchn};
      NCMD_HIT:   v = {8'd0, p.hit};
      NCMD_GND:   v = {8'd0, p.gnd};
      NCMD_HUSH:  v = p.hush;
      NCMD_COUNT: v = {12'd0, p.count};
      NCMD_DAC:   v = {8'd0, p.dac};
      NCMD_RATIO: v = {8'd0, p.ratio};
      NCMD_TICK:  v = {8'd0, p.tick};
      default:    v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ctrl_param_entry.sv
// One shadow/active register pair. Commit copies shadow into active; revert
// copies active back into shadow. A write landing with a commit goes to the
// shadow only, so active picks up the pre-write shadow value.
module ctrl_param_entry #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_mask,
  input  logic [W-1:0] wr_data,
  input  logic         commit,
  input  logic         revert,
  output logic [W-1:0] active
);

  logic [W-1:0] shadow;

  // Shadow/active update; revert takes priority over a masked write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= RST;
      active <= RST;
    end else begin
      if (commit) active <= shadow;
      if (revert) shadow <= active;
      else if (wr_en) shadow <= (shadow & ~wr_mask) | (wr_data & wr_mask);
    end
  end

endmodule

// File: rtl/ctrl_param_bank.sv
// Double-buffered parameter store for the pulser/ADC/DAC time-slot engine.
// Host commands edit the shadow bank; a commit is armed and applied atomically
// at the next frame boundary. Outputs follow the active bank for i_slot.
module ctrl_param_bank
  import ctrl_param_pkg::*;
#(
  parameter int          N_CH   = 4,
  parameter int          N_SLOT = 4,
  parameter logic [31:0] MAGIC  = 32'hF0AA550F,
  localparam int         CHW    = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int         SLW    = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        i_cmd_magic,
  input  logic [31:0]        i_cmd_command,
  input  logic               i_cmd_vld,
  output logic               o_cmd_rdy,
  output logic [31:0]        o_rsp_data,
  output logic               o_rsp_vld,
  input  logic               i_rsp_rdy,
  input  logic               i_frame_start,
  input  logic [SLW-1:0]     i_slot,
  output logic               o_commit,
  output logic               o_armed,
  output logic [7:0]         o_err_cnt,
  output logic [15:0]        o_ts_time,
  output logic [N_CH*4-1:0]  o_pulse_mask,
  output logic [N_CH*8-1:0]  o_pulse_hit,
  output logic [N_CH*8-1:0]  o_pulse_gnd,
  output logic [N_CH*4-1:0]  o_pulse_count,
  output logic [N_CH*16-1:0] o_pulse_hush,
  output logic [N_CH*2-1:0]  o_adc_vchn,
  output logic [N_CH*8-1:0]  o_adc_tick,
  output logic [N_CH*8-1:0]  o_adc_ratio,
  output logic [N_CH*8-1:0]  o_dac_level
);

  logic                  cmd_fire, magic_ok, cmd_global;
  logic [CMD_IDX_W-1:0]  cmd_ncmd, cmd_ch, cmd_slot;
  logic [CMD_DATA_W-1:0] cmd_data;
  logic                  unused_cmd_bits;
  logic                  ch_ok, slot_ok, ncmd_chan;
  logic                  wr_chan, wr_time, do_commit_cmd, do_read, do_revert_cmd, cmd_bad;
  logic                  commit_now, revert_all;
  chan_param_t           wr_mask, wr_data;

  assign o_cmd_rdy  = ~o_rsp_vld;
  assign cmd_fire   = i_cmd_vld & o_cmd_rdy;
  assign magic_ok   = (i_cmd_magic == MAGIC);
  assign cmd_global = i_cmd_command[CMD_GLOBAL_BIT];
  assign cmd_ncmd   = i_cmd_command[CMD_NCMD_LSB +: CMD_IDX_W];
  assign cmd_ch     = i_cmd_command[CMD_CH_LSB +: CMD_IDX_W];
  assign cmd_slot   = i_cmd_command[CMD_SLOT_LSB +: CMD_IDX_W];
  assign cmd_data   = i_cmd_command[CMD_DATA_LSB +: CMD_DATA_W];
  assign unused_cmd_bits = ^i_cmd_command[18:16];

  assign ch_ok     = ({1'b0, cmd_ch} < 5'(N_CH));
  assign slot_ok   = ({1'b0, cmd_slot} < 5'(N_SLOT));
  assign ncmd_chan = (cmd_ncmd >= NCMD_MASK) && (cmd_ncmd <= NCMD_TICK);

  assign wr_chan       = cmd_fire && magic_ok && !cmd_global && ncmd_chan && ch_ok && slot_ok;
  assign wr_time       = cmd_fire && magic_ok && !cmd_global && (cmd_ncmd == NCMD_TIME) && slot_ok;
  assign do_commit_cmd = cmd_fire && magic_ok && cmd_global && (cmd_ncmd == GCMD_COMMIT);
  assign do_read       = cmd_fire && magic_ok && cmd_global && (cmd_ncmd == GCMD_READ);
  assign do_revert_cmd = cmd_fire && magic_ok && cmd_global && (cmd_ncmd == GCMD_REVERT);
  // Anything accepted that maps to no valid action counts as a rejection
  assign cmd_bad = cmd_fire && !(wr_chan || wr_time || do_commit_cmd || do_read || do_revert_cmd);

  assign commit_now = i_frame_start && o_armed;
  assign revert_all = do_revert_cmd && !commit_now;

  assign wr_mask = place_field(cmd_ncmd, 16'hFFFF);
  assign wr_data = place_field(cmd_ncmd, cmd_data);

  chan_param_t act    [N_CH][N_SLOT];
  logic [15:0] ts_act [N_SLOT];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    for (genvar s = 0; s < N_SLOT; s++) begin : g_slot
      ctrl_param_entry #(
        .W   (PARAM_W),
        .RST (default_entry(c, s, N_CH, N_SLOT))
      ) u_entry (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_chan && (cmd_ch[CHW-1:0] == CHW'(c)) && (cmd_slot[SLW-1:0] == SLW'(s))),
        .wr_mask (wr_mask),
        .wr_data (wr_data),
        .commit  (commit_now),
        .revert  (revert_all),
        .active  (act[c][s])
      );
    end
  end

  for (genvar s = 0; s < N_SLOT; s++) begin : g_ts
    ctrl_param_entry #(
      .W   (TIME_W),
      .RST (DEF_TS_TIME)
    ) u_ts (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_time && (cmd_slot[SLW-1:0] == SLW'(s))),
      .wr_mask ({TIME_W{1'b1}}),
      .wr_data (cmd_data),
      .commit  (commit_now),
      .revert  (revert_all),
      .active  (ts_act[s])
    );
  end

  chan_param_t rd_p;
  logic [15:0] rd_ts;
  logic [3:0]  rd_field;
  logic        rd_bad;
  logic [31:0] rd_word;

  // Readback mux over the active bank; ch is irrelevant for the slot period
  always_comb begin
    rd_p  = '0;
    rd_ts = '0;
    for (int c = 0; c < N_CH; c++)
      for (int s = 0; s < N_SLOT; s++)
        if (cmd_ch == 4'(c) && cmd_slot == 4'(s)) rd_p = act[c][s];
    for (int s = 0; s < N_SLOT; s++)
      if (cmd_slot == 4'(s)) rd_ts = ts_act[s];
    rd_field = cmd_data[3:0];
    rd_bad   = !slot_ok || (rd_field == 4'd0) || (rd_field > NCMD_TIME) ||
               ((rd_field != NCMD_TIME) && !ch_ok);
    if (rd_bad)                      rd_word = ERR_READ_TAG | {24'd0, cmd_ch, cmd_slot};
    else if (rd_field == NCMD_TIME)  rd_word = {16'd0, rd_ts};
    else                             rd_word = {16'd0, get_field(rd_p, rd_field)};
  end

  chan_param_t cur [N_CH];
  logic [15:0] cur_ts;
  chan_param_t out_q [N_CH];

  // Per-channel slot select; an out-of-range slot yields zeros
  always_comb begin
    cur_ts = '0;
    for (int c = 0; c < N_CH; c++) begin
      cur[c] = '0;
      for (int s = 0; s < N_SLOT; s++)
        if (i_slot == SLW'(s)) cur[c] = act[c][s];
    end
    for (int s = 0; s < N_SLOT; s++)
      if (i_slot == SLW'(s)) cur_ts = ts_act[s];
  end

  // Registered parameter outputs, resetting to the slot-0 defaults
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) out_q[c] <= default_entry(c, 0, N_CH, N_SLOT);
      o_ts_time <= DEF_TS_TIME;
    end else begin
      for (int c = 0; c < N_CH; c++) out_q[c] <= cur[c];
      o_ts_time <= cur_ts;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_out
    assign o_pulse_mask [c*4  +: 4]  = out_q[c].mask;
    assign o_pulse_hit  [c*8  +: 8]  = out_q[c].hit;
    assign o_pulse_gnd  [c*8  +: 8]  = out_q[c].gnd;
    assign o_pulse_count[c*4  +: 4]  = out_q[c].count;
    assign o_pulse_hush [c*16 +: 16] = out_q[c].hush;
    assign o_adc_vchn   [c*2  +: 2]  = out_q[c].vchn;
    assign o_adc_tick   [c*8  +: 8]  = out_q[c].tick;
    assign o_adc_ratio  [c*8  +: 8]  = out_q[c].ratio;
    assign o_dac_level  [c*8  +: 8]  = out_q[c].dac;
  end

  // Commit arming, commit pulse, error counter and readback response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_armed    <= 1'b0;
      o_commit   <= 1'b0;
      o_err_cnt  <= 8'd0;
      o_rsp_vld  <= 1'b0;
      o_rsp_data <= 32'd0;
    end else begin
      o_commit <= commit_now;
      if (do_commit_cmd)             o_armed <= 1'b1;
      else if (commit_now || revert_all) o_armed <= 1'b0;
      if (cmd_bad && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      if (do_read) begin
        o_rsp_vld  <= 1'b1;
        o_rsp_data <= rd_word;
      end else if (o_rsp_vld && i_rsp_rdy) begin
        o_rsp_vld <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ctrl_param_bank.md
Name: ctrl_param_bank

Overview:
- Parametrised, double-buffered parameter store for the pulser/ADC/DAC time-slot engine.
- Host commands write a shadow bank. A commit command arms an atomic copy of shadow to the active bank, taken at the next frame boundary, so parameters never change mid-frame.
- Drives per-channel parameters for the currently selected slot, with one cycle of registered latency.
- Adds register readback, out-of-range rejection and error counting.

Parameters:
- N_CH, 4, number of channels (1..16).
- N_SLOT, 4, number of time slots (1..16).
- MAGIC, 32'hF0AA550F, required command magic word.
- CHW, $clog2(N_CH) (min 1), channel index width (derived).
- SLW, $clog2(N_SLOT) (min 1), slot index width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_cmd_magic  in  32  must equal MAGIC
- i_cmd_command  in  32  command word
- i_cmd_vld  in  1  command valid
- o_cmd_rdy  out  1  command ready
- o_rsp_data  out  32  readback data
- o_rsp_vld  out  1  readback valid
- i_rsp_rdy  in  1  readback accept
- i_frame_start  in  1  one-cycle frame boundary strobe
- i_slot  in  SLW  current slot
- o_commit  out  1  one-cycle pulse when active bank updated
- o_armed  out  1  commit pending
- o_err_cnt  out  8  saturating count of rejected commands
- o_ts_time  out  16  active slot period for i_slot
- o_pulse_mask/o_pulse_hit/o_pulse_gnd/o_pulse_count/o_pulse_hush/o_adc_vchn/o_adc_tick/o_adc_ratio/o_dac_level  out  N_CH*{4,8,8,4,16,2,8,8,8}  flattened per-channel fields; channel c is at slice [c*W +: W]

Behaviour:
- Reset and interface:
  - Reset is asynchronous, active-low on rst_n; clock is clk.
  - Handshake: a command is accepted when i_cmd_vld && o_cmd_rdy.
  - o_cmd_rdy = ~o_rsp_vld.
  - An accepted command with magic != MAGIC is dropped and increments o_err_cnt, which saturates at 255.
- Command fields:
  - [31] global; [30:27] ncmd; [26:23] ch; [22:19] slot; [15:0] data.
- Local commands (global=0), written to shadow[ch][slot]:
  - 1 = mask, data[3:0]
  - 2 = vchn, data[1:0]
  - 3 = hit, data[7:0]
  - 4 = gnd, data[7:0]
  - 5 = hush, data[15:0]
  - 6 = count, data[3:0]
  - 7 = dac, data[7:0]
  - 8 = ratio, data[7:0]
  - 9 = tick, data[7:0]
  - 10 = ts_time[slot], data[15:0]; ch is ignored.
  - ch >= N_CH, slot >= N_SLOT, or an undefined ncmd: no write, err_cnt+1.
- Global commands:
  - 1 = COMMIT: sets armed.
  - 2 = READ: field = data[3:0] (local ncmd codes), read from the ACTIVE bank at [ch][slot]. The cycle after accept, o_rsp_vld=1 and o_rsp_data = zero-extended value. The response is held until i_rsp_rdy. A bad index or field is not an error; it returns 32'hDEAD_0000 | {ch,slot}.
  - 3 = REVERT: shadow <= active (all entries) and armed is cleared.
  - Others: err_cnt+1.
- Commit:
  - On i_frame_start && armed, active <= shadow (all entries) in one cycle; armed clears; o_commit=1 for the next cycle.
  - COMMIT accepted in the same cycle as i_frame_start does not apply until the following frame_start.
  - A shadow write in the same cycle as the commit copy: active receives the old shadow value and the shadow holds the new one.
  - REVERT in the same cycle as a commit: the commit wins and the revert is ignored.
- Outputs:
  - Registered from active[c][i_slot]; one cycle latency after an i_slot or active change.
  - i_slot >= N_SLOT drives zeros.
- Reset defaults, both banks, all c,s:
  - ts_time 3600
  - mask 1<<(c%4)
  - hit 40 (20 if c,s are both last)
  - gnd 40 (60 if c,s are both last)
  - count 4 (1 if c,s are both last)
  - hush 1000
  - vchn c[1:0]
  - tick 64
  - ratio 12
  - dac 120
- Reset values of the remaining outputs:
  - armed=0, o_commit=0, o_rsp_vld=0, o_rsp_data=0, err_cnt=0.
  - Outputs show the slot-0 defaults.
- Reset mid-operation: a pending response and armed state are discarded.

Decomposition:
- Package ctrl_param_pkg:
  - NCMD_* and GCMD_* constants
  - command bit-field positions
  - field widths
  - default values
  - ERR_READ_TAG
- Sub-module ctrl_param_entry: one shadow/active pair for a single (ch,slot), with write-enable, commit and revert inputs. It is instantiated N_CH*N_SLOT times in a generate loop. ts_time uses a per-slot instance of the same pattern.

Test Plan:
1. Write HIT ch1 slot2 = 0x55, no commit, i_slot=2 -> o_pulse_hit[15:8] stays 40. Then COMMIT and frame_start -> 0x55 one cycle later, with a single o_commit pulse.
2. COMMIT in the same cycle as frame_start -> no update. Next frame_start -> update, and o_armed falls.
3. Write with magic 0x12345678, and a write with ch=5 when N_CH=4 -> no state change, o_err_cnt=2. Then 256 bad commands -> o_err_cnt holds at 255.
4. READ DAC ch0 slot0 with i_rsp_rdy=0 for 5 cycles -> o_rsp_vld held with data 120 and o_cmd_rdy=0 throughout. Raise i_rsp_rdy -> handshake completes and o_cmd_rdy returns to 1.
5. Write SLOT_TIME slot3=800, then REVERT, COMMIT and frame_start -> o_ts_time for slot3 stays 3600.
6. Assert rst_n low while armed and while a response is pending -> all outputs return to defaults immediately (asynchronously), with o_rsp_vld=0 and o_armed=0.
